rca_8bit_checker: RTL
=====================

# rca_8bit_checker

Self-checking response monitor for the 8-bit ripple-carry adder: consumes one stimulus/response vector per handshake (operands, carry-in, and the sum/carry-out observed from the adder under test), recomputes the golden result with an internal bit-serial adder, compares, and keeps pass/fail statistics. It sits at the observing end of the adder test harness, opposite the stimulus source, and lets adder regressions run in hardware or simulation without manual waveform inspection.

## Interface
- WIDTH, 8, operand width in bits (minimum 1)
- CNT_W, 16, width of the pass and fail counters (minimum 1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  vector present on the A_in/B_in/C_in/sum_in/C_out_in inputs
- ready_out  out  1  checker idle, able to accept a vector
- A_in  in  WIDTH  operand A applied to the adder
- B_in  in  WIDTH  operand B applied to the adder
- C_in  in  1  carry-in applied to the adder
- sum_in  in  WIDTH  sum observed from the adder
- C_out_in  in  1  carry-out observed from the adder
- done  out  1  one-cycle pulse, comparison result valid
- pass  out  1  result of last comparison (1 = match), held until next done
- pass_cnt  out  CNT_W  number of matching vectors, saturating
- fail_cnt  out  CNT_W  number of mismatching vectors, saturating

## Operation
- FSM states: IDLE, SHIFT, COMPARE.
- IDLE: ready_out=1. When valid_in and ready_out are both high at a clock edge, the block latches all five inputs, loads the golden carry with C_in, clears the bit index, and moves to SHIFT.
- SHIFT: ready_out=0. Each cycle computes one golden bit, LSB first: g[i]=a[i]^b[i]^c, c=maj(a[i],b[i],c). After bit WIDTH-1 the block moves to COMPARE.
- COMPARE: the block compares {c, g} with the latched {C_out_in, sum_in}. All WIDTH+1 bits must match. Then done<=1, pass<=match, and the block increments pass_cnt or fail_cnt. It returns to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- valid_in while ready_out=0 is ignored. The vector is not queued.
- Inputs other than valid_in are don't-care except at the acceptance edge.

## Timing
- Reset values: ready_out=1, done=0, pass=0, pass_cnt=0, fail_cnt=0. State is IDLE and internal registers are zero.
- Let E0 be the acceptance edge. SHIFT processes one bit on each of edges E1..EWIDTH, and state is COMPARE after EWIDTH.
- At edge EWIDTH+1, done goes high for exactly one cycle, and pass and the counters update. ready_out returns to 1 in the same cycle.
- Earliest next acceptance is edge EWIDTH+2. Sustained throughput is one vector per WIDTH+2 cycles (10 for WIDTH=8).
- rst takes priority over everything at any edge.
- Reset mid-operation discards the in-flight vector. No done is generated, and the counters clear.
- The golden carry is computed at full width. Overflow is reported only through C_out, with no modular masking beyond WIDTH+1 bits.

## Configuration
- RCA_CHK_CAPTURE_EN defined:
  - Adds output first_fail_vec [2*WIDTH:0] = {A, B, C_in} of the first mismatching vector since reset.
  - Adds output first_fail_valid (1 bit, sticky). It is set in the same cycle as the first failing done and is cleared only by rst.
  - Later failures do not overwrite first_fail_vec.
  - Both outputs reset to 0.
- RCA_CHK_CAPTURE_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Correct result: A=3, B=4, C_in=0, sum_in=00000111, C_out_in=0 -> done 9 edges after acceptance, pass=1, pass_cnt=1, fail_cnt=0.
- Incorrect result: A=7, B=9, C_in=0, sum_in=00000000, C_out_in=1 -> pass=0, fail_cnt=1. The golden value is sum 00010000 with C_out 0. With RCA_CHK_CAPTURE_EN: first_fail_vec={00000111,00001001,0}, first_fail_valid=1.
- Carry boundaries, all expected to pass (pass_cnt=3):
  - A=255, B=1, C_in=0, sum_in=0, C_out_in=1
  - A=255, B=255, C_in=1, sum_in=255, C_out_in=1
  - A=0, B=0, C_in=1, sum_in=1, C_out_in=0
- Busy/back-to-back: hold valid_in high continuously with two different vectors -> the second is accepted only at edge E0+10. Vectors presented while ready_out=0 produce no done.
- Reset mid-operation: assert rst for one cycle during SHIFT bit 3 -> no done pulse, pass_cnt=fail_cnt=0, ready_out=1 in the next cycle.
- Saturation: with CNT_W=2, send 5 failing vectors -> fail_cnt stays at 3, pass_cnt=0. With RCA_CHK_CAPTURE_EN, first_fail_vec holds the first failing vector only.

Source files
------------

// File: rtl/rca_8bit_checker.sv
// Response checker for an N-bit ripple-carry adder: recomputes A+B+Cin bit-serially and scores the DUT result.
// Optional first-failure capture ports are enabled by defining RCA_CHK_CAPTURE_EN.
module rca_8bit_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             C_out_in,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef RCA_CHK_CAPTURE_EN
  ,
  output logic [2*WIDTH:0] first_fail_vec,
  output logic             first_fail_valid
`endif
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMPARE
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [WIDTH-1:0]   r_g;
  logic               r_c;
  logic [IDX_W-1:0]   r_idx;
  logic               r_done;
  logic               r_pass;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_fail_cnt;

  logic               w_abit;
  logic               w_bbit;
  logic               w_match;

`ifdef RCA_CHK_CAPTURE_EN
  logic               r_cin;
  logic [2*WIDTH:0]   r_ff_vec;
  logic               r_ff_valid;
`endif

  assign w_abit  = r_a[r_idx];
  assign w_bbit  = r_b[r_idx];
  // Full WIDTH+1-bit compare: carry-out mismatch alone is a failure.
  assign w_match = ({r_c, r_g} == {r_cout, r_sum});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ready_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_idx == LAST_IDX) begin
          w_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_g        <= '0;
      r_c        <= 1'b0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_a    <= A_in;
            r_b    <= B_in;
            r_sum  <= sum_in;
            r_cout <= C_out_in;
            r_c    <= C_in;
            r_g    <= '0;
            r_idx  <= '0;
          end
        end
        S_SHIFT: begin
          r_g[r_idx] <= w_abit ^ w_bbit ^ r_c;
          r_c        <= (w_abit & w_bbit) | (w_abit & r_c) | (w_bbit & r_c);
          r_idx      <= r_idx + 1'b1;
        end
        S_COMPARE: begin
          r_done <= 1'b1;
          r_pass <= w_match;
          if (w_match) begin
            if (r_pass_cnt != '1) begin
              r_pass_cnt <= r_pass_cnt + 1'b1;
            end
          end else begin
            if (r_fail_cnt != '1) begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RCA_CHK_CAPTURE_EN
  // Only the first failure after reset is kept; later failures leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cin      <= 1'b0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE && valid_in) begin
        r_cin <= C_in;
      end
      if (r_state == S_COMPARE && !w_match && !r_ff_valid) begin
        r_ff_vec   <= {r_a, r_b, r_cin};
        r_ff_valid <= 1'b1;
      end
    end
  end

  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;
`endif

  assign done     = r_done;
  assign pass     = r_pass;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;

endmodule
